// File: rtl/pe_row_pkg.sv
// ============================================================================
// Module      : pe_row_pkg
// Description : Shared state encoding and default widths for the PE-row
//               sequencer and its valid delay line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_row_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_WGT = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int DEF_IFM_WIDTH    = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int STALL_W          = 16;

endpackage

`default_nettype wire

// File: rtl/pe_row_valid_pipe.sv
// ============================================================================
// Module      : pe_row_valid_pipe
// Description : Enabled DEPTH-deep valid-token shift register; tail_o marks
//               a psum column that is valid at the FIFO input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_row_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic tail_o
);

    logic [DEPTH-1:0] pipe_q;

    generate
        if (DEPTH == 1) begin : g_depth1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (en_i) begin
                    pipe_q <= d_i;
                end
            end
        end else begin : g_deep
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (en_i) begin
                    pipe_q <= {pipe_q[DEPTH-2:0], d_i};
                end
            end
        end
    endgenerate

    assign tail_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pe_row_seq.sv
// ============================================================================
// Module      : pe_row_seq
// Description : Upstream sequencer for a row-stationary PE row: loads the
//               kernel row, streams IFM samples, drains the pipeline and
//               raises FIFO wr_en only on valid output columns.
//               Optional: `define PE_ROW_SEQ_STALL_CNT_EN for stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_row_seq
    import pe_row_pkg::*;
#(
    parameter int IFM_WIDTH    = DEF_IFM_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int ROW_LEN      = 16,
    parameter int PIPE_LAT     = 3,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            wgt_valid,
    input  logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt_in,
    output logic                            wgt_ready,
    input  logic                            ifm_valid,
    input  logic [IFM_WIDTH-1:0]            ifm_in,
    output logic                            ifm_ready,
    input  logic                            fifo_full,
    output logic                            set_wgt,
    output logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt_o,
    output logic                            set_ifm,
    output logic                            set_reg,
    output logic [IFM_WIDTH-1:0]            ifm_o,
    output logic                            wr_en,
    output logic                            busy,
    output logic                            done,
    output logic [STALL_W-1:0]              stall_cnt
);

    localparam int                   BUB_W    = $clog2(PIPE_LAT + 1);
    localparam logic [BUB_W-1:0]     BUB_LAST = BUB_W'(PIPE_LAT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ROW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOK  = CNT_WIDTH'(KERNEL_SIZE - 1);

    logic [2:0]                          state_q,   state_d;
    logic [CNT_WIDTH-1:0]                cnt_q,     cnt_d;
    logic [BUB_W-1:0]                    bub_q,     bub_d;
    logic                                pend_q,    pend_d;
    logic                                tok_q,     tok_d;
    logic                                set_wgt_q, set_wgt_d;
    logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt_q,     wgt_d;
    logic [IFM_WIDTH-1:0]                ifm_q,     ifm_d;

    logic w_fire;
    logic w_hs;
    logic w_bub_issue;
    logic w_tail;

    // A pending strobe is held (not dropped) while the FIFO is full, so the
    // PE shift and any column write never happen against a full FIFO.
    assign w_fire      = pend_q & ~fifo_full;
    assign w_hs        = (state_q == S_STREAM) & ifm_valid & ~fifo_full;
    assign w_bub_issue = (state_q == S_DRAIN) & ~fifo_full & (bub_q != BUB_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bub_d     = bub_q;
        pend_d    = pend_q & fifo_full;
        tok_d     = tok_q;
        set_wgt_d = 1'b0;
        wgt_d     = wgt_q;
        ifm_d     = ifm_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_WGT;
                end
            end
            S_LOAD_WGT: begin
                if (wgt_valid) begin
                    wgt_d     = wgt_in;
                    set_wgt_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    ifm_d  = ifm_in;
                    pend_d = 1'b1;
                    tok_d  = (cnt_q >= CNT_TOK);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        bub_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_bub_issue) begin
                    ifm_d  = '0;
                    pend_d = 1'b1;
                    tok_d  = 1'b0;
                    bub_d  = bub_q + 1'b1;
                end else if ((bub_q == BUB_LAST) && !(pend_q && fifo_full)) begin
                    // Last bubble strobe fires this cycle; done follows it.
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bub_q     <= '0;
            pend_q    <= 1'b0;
            tok_q     <= 1'b0;
            set_wgt_q <= 1'b0;
            wgt_q     <= '0;
            ifm_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bub_q     <= bub_d;
            pend_q    <= pend_d;
            tok_q     <= tok_d;
            set_wgt_q <= set_wgt_d;
            wgt_q     <= wgt_d;
            ifm_q     <= ifm_d;
        end
    end

    pe_row_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk    (clk),
        .rst    (rst_n),
        .en_i   (w_fire),
        .d_i    (tok_q),
        .tail_o (w_tail)
    );

    assign wgt_ready = (state_q == S_LOAD_WGT);
    assign ifm_ready = (state_q == S_STREAM) & ~fifo_full;
    assign set_wgt   = set_wgt_q;
    assign wgt_o     = wgt_q;
    assign set_ifm   = w_fire;
    assign set_reg   = w_fire;
    assign ifm_o     = ifm_q;
    assign wr_en     = w_tail & w_fire;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

`ifdef PE_ROW_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;
    logic               w_stall;

    assign w_stall = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                     (fifo_full || ((state_q == S_STREAM) && !ifm_valid));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stall_q <= '0;
        end else if (start && (state_q == S_IDLE)) begin
            stall_q <= '0;
        end else if (w_stall && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_row_seq.sv
// ============================================================================
// Module      : tb_pe_row_seq
// Description : Self-checking bench for pe_row_seq; IFM samples are pushed to
//               a scoreboard on handshake and popped on set_ifm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pe_row_seq;

    localparam int IW   = 8;
    localparam int WW   = 8;
    localparam int KS   = 3;
    localparam int RL   = 16;
    localparam int PL   = 3;
    localparam int CW   = 5;
    localparam int N_WR = RL - KS + 1;
`ifdef PE_ROW_SEQ_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             start     = 1'b0;
    logic             wgt_valid = 1'b0;
    logic [KS*WW-1:0] wgt_in    = '0;
    logic             ifm_valid = 1'b0;
    logic [IW-1:0]    ifm_in    = '0;
    logic             fifo_full = 1'b0;
    logic             wgt_ready, ifm_ready, set_wgt, set_ifm, set_reg;
    logic             wr_en, busy, done;
    logic [KS*WW-1:0] wgt_o;
    logic [IW-1:0]    ifm_o;
    logic [15:0]      stall_cnt;

    always #5 clk = ~clk;

    pe_row_seq #(
        .IFM_WIDTH    (IW),
        .WEIGHT_WIDTH (WW),
        .KERNEL_SIZE  (KS),
        .ROW_LEN      (RL),
        .PIPE_LAT     (PL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wgt_valid (wgt_valid),
        .wgt_in    (wgt_in),
        .wgt_ready (wgt_ready),
        .ifm_valid (ifm_valid),
        .ifm_in    (ifm_in),
        .ifm_ready (ifm_ready),
        .fifo_full (fifo_full),
        .set_wgt   (set_wgt),
        .wgt_o     (wgt_o),
        .set_ifm   (set_ifm),
        .set_reg   (set_reg),
        .ifm_o     (ifm_o),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            e_cnt   = 0;
    int            n_wr    = 0;
    int            n_setifm = 0;
    int            n_setwgt = 0;
    int            n_done  = 0;
    int            cyc     = 0;
    int            last_wr = 0;
    bit            mon_en  = 1'b0;
    logic [KS*WW-1:0] exp_wgt = '0;
    logic [IW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({busy, done, set_wgt, set_ifm, set_reg,
                                     wr_en, wgt_ready, ifm_ready}), 32'd0);
        check_eq({tag, "_wgt_o"}, 32'(wgt_o), 32'd0);
        check_eq({tag, "_ifm_o"}, 32'(ifm_o), 32'd0);
        check_eq({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    endtask

    // Column model: the e-th enabled cycle of a row writes iff its token came
    // from sample index >= KS-1, PL enabled cycles earlier.
    always @(negedge clk) begin
        cyc++;
        if (mon_en && (rst_n == 1'b0)) begin
            if (fifo_full) begin
                check_eq("strobe_in_stall", 32'({set_ifm, set_reg, wr_en}), 32'd0);
            end
            if (set_reg || wr_en) begin
                check_eq("wr_en_col", 32'(wr_en),
                         32'((e_cnt >= KS - 1 + PL) && (e_cnt <= RL + PL - 1)));
                if (wr_en) begin
                    n_wr++;
                    last_wr = cyc;
                end
                if (set_reg) e_cnt++;
            end
            if (set_ifm) begin
                n_setifm++;
                check_eq("ifm_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("ifm_o", 32'(ifm_o), 32'(exp_q.pop_front()));
            end
            if (set_wgt) begin
                n_setwgt++;
                check_eq("wgt_o_load", 32'(wgt_o), 32'(exp_wgt));
            end
            if (done) begin
                n_done++;
                check_eq("done_latency", 32'(cyc - last_wr), 32'd1);
            end
        end
    end

    task automatic run_row(input logic [KS*WW-1:0] w, input int stall_after,
                           input int stall_len, input bit toggle, input bit poke,
                           input int abort_after, input int exp_stall);
        int k          = 0;
        int cyc_n      = 0;
        int stall_left = 0;
        bit phase      = 1'b1;
        bit aborted    = 1'b0;
        e_cnt = 0; n_wr = 0; n_setifm = 0; n_setwgt = 0; n_done = 0;
        exp_q.delete();
        exp_wgt = w;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        wgt_in    = w;
        wgt_valid = 1'b1;
        @(negedge clk);
        check_eq("wgt_ready_load", 32'(wgt_ready), 32'd1);
        @(posedge clk); #1;
        wgt_valid = poke;
        if (poke) wgt_in = ~w;
        while (k < RL && cyc_n < 400 && !aborted) begin
            fifo_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            ifm_valid = toggle ? phase : 1'b1;
            phase     = ~phase;
            ifm_in    = IW'(k + 1);
            start     = poke && (k == 5);
            @(negedge clk);
            if (fifo_full) check_eq("ifm_ready_stall", 32'(ifm_ready), 32'd0);
            if (poke && k == 1) check_eq("wgt_ready_stream", 32'(wgt_ready), 32'd0);
            if (ifm_valid && ifm_ready) begin
                exp_q.push_back(ifm_in);
                k++;
                if (k == RL) begin
                    for (int b = 0; b < PL; b++) exp_q.push_back('0);
                end
                if (k == stall_after) stall_left = stall_len;
            end
            @(posedge clk); #1;
            cyc_n++;
            if (k == abort_after) aborted = 1'b1;
        end
        if (aborted) begin
            #2 rst_n = 1'b1;
            #1 check_outputs_zero("abort");
            start = 1'b0; ifm_valid = 1'b0; fifo_full = 1'b0; wgt_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (5) @(posedge clk);
            #1 check_eq("abort_no_done", 32'(n_done), 32'd0);
            check_eq("abort_idle", 32'(busy), 32'd0);
            return;
        end
        start = 1'b0; ifm_valid = 1'b0; fifo_full = 1'b0; wgt_valid = 1'b0;
        check_eq("samples_accepted", 32'(k), 32'(RL));
        for (int i = 0; i < 50 && n_done == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_count", 32'(n_done), 32'd1);
        check_eq("wr_en_count", 32'(n_wr), 32'(N_WR));
        check_eq("set_ifm_count", 32'(n_setifm), 32'(RL + PL));
        check_eq("set_wgt_count", 32'(n_setwgt), 32'd1);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_eq("idle_after_row", 32'(busy), 32'd0);
        check_eq("wgt_o_held", 32'(wgt_o), 32'(w));
        check_eq("stall_cnt", 32'(stall_cnt), STALL_EN ? 32'(exp_stall) : 32'd0);
    endtask

    initial begin
        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        run_row(24'h010203, -1, 0, 1'b0, 1'b0, -1, 0);
        run_row(24'h010203,  8, 4, 1'b0, 1'b0, -1, 4);
        run_row(24'h040506, -1, 0, 1'b1, 1'b0, -1, 15);
        run_row(24'h070809, -1, 0, 1'b0, 1'b0,  8, 0);
        run_row(24'h0A0B0C, -1, 0, 1'b0, 1'b0, -1, 0);
        run_row(24'h010203, -1, 0, 1'b0, 1'b1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
